capture_frame_controller: RTL and testbench
===========================================

# capture_frame_controller

Sequencer for the OV7670 capture path. It arms on a software request, aligns to the camera frame boundary (VSYNC), and gates pixel capture. It also generates the dual-port RAM write address and write strobe for each RGB332 pixel assembled from the camera's two-byte pixel stream. It sits between the camera sync inputs and the frame buffer write port, replacing free-running address counting with frame-aligned, bounded, error-checked writes.

## Interface
Parameters:
- H_PIX, 160, pixels stored per line (each pixel = 2 camera bytes).
- V_LINES, 120, lines stored per frame.
- AW, 15, RAM address width; H_PIX*V_LINES must be ≤ 2^AW.

Ports:
- PCLK  in  1  camera pixel clock; the only clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to capture; ignored unless state is IDLE.
- continuous  in  1  sampled at DONE: 1 = re-arm for next frame, 0 = return to IDLE.
- VSYNC  in  1  camera vertical sync, high between frames.
- HREF  in  1  camera line valid, high while bytes are presented.
- byte_phase  out  1  0 = first byte of pixel (R/G high), 1 = second byte; steers the downsampler.
- DP_RAM_addr_in  out  AW  pixel write address, row*H_PIX + col.
- DP_RAM_regW  out  1  one-cycle write strobe per stored pixel.
- busy  out  1  high in ARM, CAPTURE, DONE.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- line_err  out  1  sticky; a line ended with col ≠ H_PIX or extra lines arrived. Cleared by start or rst.
- lines_seen  out  8  lines counted in the last/current frame, saturating at 255.

## Operation
- States: IDLE, ARM, CAPTURE, DONE.
- IDLE: outputs quiescent. start → ARM and clear line_err.
- ARM: wait for a VSYNC falling edge (registered VSYNC_d=1, VSYNC=0) → CAPTURE.
  - Clear row, col, addr, byte_phase and lines_seen on that transition.
  - A start issued mid-frame therefore never captures a partial frame.
- CAPTURE:
  - Each cycle with HREF=1 toggles byte_phase. byte_phase is forced to 0 on HREF rising edge.
  - When byte_phase=1 and HREF=1, the pixel is complete:
    - If row < V_LINES and col < H_PIX: assert DP_RAM_regW next cycle with the current addr, then increment col and addr.
    - Otherwise drop the pixel and set line_err if row < V_LINES.
  - HREF falling edge:
    - If col ≠ H_PIX, set line_err.
    - If row ≥ V_LINES, set line_err. Extra lines are never written.
    - row++ saturating at V_LINES, lines_seen++ saturating, col=0, byte_phase=0.
  - VSYNC rising edge → DONE. If row ≠ V_LINES, set line_err.
- DONE: one cycle, frame_done=1. Then go to ARM if continuous=1, else IDLE.
- Address arithmetic is a running counter, with no multiplier. The maximum addr written is H_PIX*V_LINES−1. addr never wraps within a frame.
- rst in any state: state=IDLE.
  - All outputs 0: byte_phase, DP_RAM_addr_in, DP_RAM_regW, busy, frame_done, line_err, lines_seen.
  - All internal counters and edge-detect registers 0.
- HREF high while in IDLE or ARM: ignored, no strobes.
- VSYNC rising in the same cycle as a completed pixel: the pixel write is still issued, and DONE follows.

## Timing
- All outputs are registered.
- DP_RAM_regW and DP_RAM_addr_in are valid together, 1 PCLK after the second-byte sample edge. Address is stable for the strobe cycle.
- Strobe spacing is ≥ 2 PCLK (one per byte pair).
- ARM→CAPTURE occurs 1 PCLK after the VSYNC falling edge is sampled.
- CAPTURE→DONE occurs 1 PCLK after the VSYNC rising edge is sampled.
- frame_done is a single cycle. busy drops the cycle after DONE when continuous=0.
- start asserted during busy has no effect.

## Test plan
- Nominal frame with H_PIX=4, V_LINES=3:
  - Stimulus: start, one VSYNC pulse, 3 lines of 8 bytes, VSYNC high.
  - Required: 12 strobes, addr 0..11 in order; frame_done once; line_err=0; lines_seen=3; state IDLE.
- Start mid-frame:
  - Stimulus: start while HREF lines are active.
  - Required: no strobes until the next VSYNC falling edge, then a full frame from addr 0.
- Long and short lines:
  - Stimulus: line 0 has 10 bytes, line 1 has 6 bytes.
  - Required: line 0 writes only addr 0..3 (bytes 9–10 dropped); line 1 writes addr 4..6; line_err=1; next line starts at addr 8.
- Extra lines:
  - Stimulus: 5 lines in a frame.
  - Required: no writes beyond addr 11; line_err=1; lines_seen=5.
- Continuous mode:
  - Stimulus: continuous=1 over 2 frames.
  - Required: two frame_done pulses; second frame restarts at addr 0; busy stays 1 between frames.
- Reset mid-CAPTURE:
  - Stimulus: rst for 1 cycle.
  - Required: all outputs 0 next cycle; subsequent HREF activity produces no strobes until a new start and VSYNC fall.

Source files
------------

// File: rtl/capture_frame_controller.sv
// capture_frame_controller
//   Frame-aligned capture sequencer for an OV7670 byte stream (two bytes per
//   RGB332 pixel). Arms on start, waits for a VSYNC falling edge, then produces
//   one RAM write strobe and address per stored pixel. It bounds writes to
//   H_PIX x V_LINES and flags malformed lines.
//
// Ports
//   PCLK            camera pixel clock (only clock, rising edge)
//   rst             synchronous active-high reset
//   start           one-cycle capture request, honoured only in IDLE
//   continuous      sampled in DONE: 1 re-arms, 0 returns to IDLE
//   VSYNC, HREF     camera frame / line sync
//   byte_phase      phase of the byte currently on the bus (0 = first byte)
//   DP_RAM_addr_in  write address (row*H_PIX + col), valid with DP_RAM_regW
//   DP_RAM_regW     one-cycle write strobe per stored pixel
//   busy            high in ARM, CAPTURE and DONE
//   frame_done      one-cycle pulse while in DONE
//   line_err        sticky malformed-line/frame flag, cleared by start or rst
//   lines_seen      lines seen in the last/current frame, saturating at 255
module capture_frame_controller #(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int AW      = 15
) (
    input  logic          PCLK,
    input  logic          rst,
    input  logic          start,
    input  logic          continuous,
    input  logic          VSYNC,
    input  logic          HREF,
    output logic          byte_phase,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic          DP_RAM_regW,
    output logic          busy,
    output logic          frame_done,
    output logic          line_err,
    output logic [7:0]    lines_seen
);
    localparam int CW = $clog2(H_PIX + 1);
    localparam int RW = $clog2(V_LINES + 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(H_PIX);
    localparam logic [RW-1:0] ROW_MAX   = RW'(V_LINES);
    localparam logic [AW:0]   LINE_STEP = (AW+1)'(H_PIX);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
    state_t state_q, state_d;

    logic          vsync_q, href_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    // One extra bit so the next-row address after the last line
    // (H_PIX*V_LINES) can be held even when it equals 2^AW.
    logic [AW:0]   addr_q, addr_d, base_q, base_d;
    logic          bp_q, bp_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic [7:0]    seen_q, seen_d;
    logic          busy_q, done_q;

    logic vs_fall, vs_rise, href_rise, href_fall, phase_eff;

    assign vs_fall   =  vsync_q & ~VSYNC;
    assign vs_rise   = ~vsync_q &  VSYNC;
    assign href_rise = ~href_q  &  HREF;
    assign href_fall =  href_q  & ~HREF;
    // The first byte of a line is always phase 0, whatever the toggle says.
    assign phase_eff = href_rise ? 1'b0 : bp_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        base_d  = base_q;
        bp_d    = bp_q;
        waddr_d = waddr_q;
        wr_d    = 1'b0;
        err_d   = err_q;
        seen_d  = seen_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    err_d   = 1'b0;
                end
            end
            ARM: begin
                if (vs_fall) begin
                    state_d = CAPTURE;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    base_d  = '0;
                    bp_d    = 1'b0;
                    seen_d  = '0;
                end
            end
            CAPTURE: begin
                if (HREF) begin
                    bp_d = ~phase_eff;
                    if (phase_eff) begin
                        if (row_q < ROW_MAX && col_q < COL_MAX) begin
                            wr_d    = 1'b1;
                            waddr_d = addr_q[AW-1:0];
                            col_d   = col_q + 1'b1;
                            addr_d  = addr_q + 1'b1;
                        end else if (row_q < ROW_MAX) begin
                            err_d = 1'b1;
                        end
                    end
                end else if (href_fall) begin
                    if (col_q != COL_MAX || row_q >= ROW_MAX)
                        err_d = 1'b1;
                    // Short lines still advance to the next row start.
                    if (row_q < ROW_MAX) begin
                        row_d  = row_q + 1'b1;
                        base_d = base_q + LINE_STEP;
                        addr_d = base_q + LINE_STEP;
                    end
                    if (seen_q != 8'hFF)
                        seen_d = seen_q + 8'd1;
                    col_d = '0;
                    bp_d  = 1'b0;
                end
                if (vs_rise) begin
                    state_d = DONE;
                    if (row_d != ROW_MAX)
                        err_d = 1'b1;
                end
            end
            DONE: begin
                state_d = continuous ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (rst) begin
            state_q <= IDLE;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            base_q  <= '0;
            bp_q    <= 1'b0;
            waddr_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            seen_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= VSYNC;
            href_q  <= HREF;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            bp_q    <= bp_d;
            waddr_q <= waddr_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign byte_phase     = bp_q;
    assign DP_RAM_addr_in = waddr_q;
    assign DP_RAM_regW    = wr_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign line_err       = err_q;
    assign lines_seen     = seen_q;
endmodule

// File: tb/tb_capture_frame_controller.sv
// Bench for capture_frame_controller with a 4x3 frame. Expected write
// addresses are pushed to a queue as lines are driven and popped by a monitor
// whenever the DUT strobes. Frame-level results come from a vector table,
// and the multi-cycle corner cases are hand-written sequences.
module tb_capture_frame_controller;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;

    logic          PCLK = 1'b0;
    logic          rst, start, continuous, VSYNC, HREF;
    logic          byte_phase, DP_RAM_regW, busy, frame_done, line_err;
    logic [AW-1:0] DP_RAM_addr_in;
    logic [7:0]    lines_seen;

    capture_frame_controller #(.H_PIX(H), .V_LINES(V), .AW(AW)) dut (
        .PCLK(PCLK), .rst(rst), .start(start), .continuous(continuous),
        .VSYNC(VSYNC), .HREF(HREF), .byte_phase(byte_phase),
        .DP_RAM_addr_in(DP_RAM_addr_in), .DP_RAM_regW(DP_RAM_regW),
        .busy(busy), .frame_done(frame_done), .line_err(line_err),
        .lines_seen(lines_seen)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int fd_cnt = 0;
    int lens[8];

    typedef struct {
        int n;
        int len[8];
        bit err;
        int seen;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest expected address.
    always @(negedge PCLK) begin
        if (frame_done) fd_cnt++;
        if (DP_RAM_regW) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got addr %0d expected no write", DP_RAM_addr_in);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(DP_RAM_addr_in) != e) begin
                    errors++;
                    $display("FAIL strobe_addr: got %0d expected %0d", DP_RAM_addr_in, e);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Drive n lines with byte counts from lens[]; optionally push the
    // addresses a conforming controller must write (row*H + col).
    task automatic do_lines(input int n, input bit push);
        for (int l = 0; l < n; l++) begin
            if (push && l < V)
                for (int c = 0; c < lens[l] / 2 && c < H; c++)
                    exp_q.push_back(l * H + c);
            HREF = 1'b1;
            tick(lens[l]);
            HREF = 1'b0;
            tick(3);
        end
    endtask

    task automatic start_and_fall();
        VSYNC = 1'b1;
        tick(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        VSYNC = 1'b0;
        tick(3);
    endtask

    task automatic finish_frame(input string tag, input bit exp_busy_after);
        bit got;
        got = 1'b0;
        VSYNC = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_frame_done"}, int'(got), 1);
        tick();
        check({tag, "_done_single"}, int'(frame_done), 0);
        check({tag, "_busy_after"}, int'(busy), int'(exp_busy_after));
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{n: 3, len: '{8, 8, 8, 0, 0, 0, 0, 0}, err: 1'b0, seen: 3};
        tbl[1] = '{n: 3, len: '{10, 6, 8, 0, 0, 0, 0, 0}, err: 1'b1, seen: 3};
        tbl[2] = '{n: 5, len: '{8, 8, 8, 8, 8, 0, 0, 0}, err: 1'b1, seen: 5};
        tbl[3] = '{n: 2, len: '{8, 8, 0, 0, 0, 0, 0, 0}, err: 1'b1, seen: 2};

        rst = 1'b1; start = 1'b0; continuous = 1'b0; VSYNC = 1'b0; HREF = 1'b0;
        tick(2);
        check("rst_byte_phase", int'(byte_phase), 0);
        check("rst_addr", int'(DP_RAM_addr_in), 0);
        check("rst_regW", int'(DP_RAM_regW), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_line_err", int'(line_err), 0);
        check("rst_lines_seen", int'(lines_seen), 0);
        rst = 1'b0;
        tick(2);

        // Table-driven frames: nominal, long/short lines, extra lines, short frame.
        for (int t = 0; t < 4; t++) begin
            string tag;
            tag = $sformatf("vec%0d", t);
            for (int k = 0; k < 8; k++) lens[k] = tbl[t].len[k];
            start_and_fall();
            check({tag, "_busy_capture"}, int'(busy), 1);
            do_lines(tbl[t].n, 1'b1);
            finish_frame(tag, 1'b0);
            check({tag, "_line_err"}, int'(line_err), int'(tbl[t].err));
            check({tag, "_lines_seen"}, int'(lines_seen), tbl[t].seen);
        end

        // Start mid-frame: nothing written until the next VSYNC fall.
        for (int k = 0; k < 8; k++) lens[k] = 8;
        VSYNC = 1'b0;
        tick(3);
        HREF = 1'b1;
        tick(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(4);
        HREF = 1'b0;
        tick(3);
        check("mid_busy_arm", int'(busy), 1);
        check("mid_err_cleared", int'(line_err), 0);
        do_lines(2, 1'b0);
        VSYNC = 1'b1;
        tick(3);
        VSYNC = 1'b0;
        tick(3);
        do_lines(3, 1'b1);
        finish_frame("mid", 1'b0);
        check("mid_line_err", int'(line_err), 0);

        // Continuous: two frames, busy held high across the re-arm.
        fd_cnt = 0;
        continuous = 1'b1;
        start_and_fall();
        do_lines(3, 1'b1);
        finish_frame("cont1", 1'b1);
        VSYNC = 1'b0;
        tick(3);
        check("cont_busy_between", int'(busy), 1);
        do_lines(3, 1'b1);
        continuous = 1'b0;
        finish_frame("cont2", 1'b0);
        check("cont_fd_count", fd_cnt, 2);

        // Reset mid-capture after an error, then HREF activity must be ignored.
        lens[0] = 10;
        start_and_fall();
        do_lines(1, 1'b1);
        check("rstmid_err_before", int'(line_err), 1);
        exp_q.push_back(4);
        HREF = 1'b1;
        tick(3);
        rst = 1'b1;
        tick();
        check("rstmid_byte_phase", int'(byte_phase), 0);
        check("rstmid_addr", int'(DP_RAM_addr_in), 0);
        check("rstmid_regW", int'(DP_RAM_regW), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_line_err", int'(line_err), 0);
        check("rstmid_lines_seen", int'(lines_seen), 0);
        rst = 1'b0;
        tick(4);
        HREF = 1'b0;
        tick(2);
        lens[0] = 8;
        VSYNC = 1'b1;
        tick(3);
        VSYNC = 1'b0;
        tick(3);
        do_lines(3, 1'b0);
        check("rstmid_idle_busy", int'(busy), 0);
        check("rstmid_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
